seg7_scan_driver: RTL and testbench

//  Consumes the one-hot digit-select ring produced by the stopwatch ring counter and drives the

---
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: ring/BCD/dp requests in, anode/segment pins out.
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [N_DIGITS-1:0]   ring;
  logic [4*N_DIGITS-1:0] bcd;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  blank_lz;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp_n;
  logic                  ring_err;

  modport master (
    output ring, bcd, dp_in, blank_lz,
    input  an, seg, dp_n, ring_err
  );

  modport slave (
    input  ring, bcd, dp_in, blank_lz,
    output an, seg, dp_n, ring_err
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: dead time on every digit change, per-frame BCD snapshot,
// leading-zero blanking and illegal ring detection.
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned BW = 4 * N_DIGITS;
  localparam int unsigned CW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (DEAD_CYCLES == 0) ? '0 : CW'(DEAD_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t              state_q, state_nxt;
  logic [CW-1:0]       cnt_q, cnt_nxt;
  logic [N_DIGITS-1:0] ring_q;
  logic [BW-1:0]       snap_q, snap_nxt;
  logic [N_DIGITS-1:0] an_q, an_nxt;
  logic [6:0]          seg_q, seg_nxt;
  logic                dp_q, dp_nxt;
  logic                err_q, err_nxt;

  logic                valid;
  logic                change;
  logic [N_DIGITS-1:0] lz;
  logic [3:0]          nib;
  logic                lz_blank;
  logic                dp_req;

  assign valid  = $onehot(bus.ring);
  assign change = (bus.ring != ring_q);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0:    decode = 7'h40;
      4'h1:    decode = 7'h79;
      4'h2:    decode = 7'h24;
      4'h3:    decode = 7'h30;
      4'h4:    decode = 7'h19;
      4'h5:    decode = 7'h12;
      4'h6:    decode = 7'h02;
      4'h7:    decode = 7'h78;
      4'h8:    decode = 7'h00;
      4'h9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // State, counter, snapshot and registered pins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      ring_q  <= '0;
      snap_q  <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      ring_q  <= bus.ring;
      snap_q  <= snap_nxt;
      an_q    <= an_nxt;
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next state: an illegal ring forces blanking; a legal change restarts the dead time
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    snap_nxt  = snap_q;
    if (change && bus.ring[0]) begin
      snap_nxt = bus.bcd;
    end
    if (!valid) begin
      state_nxt = BLANK;
    end else if (change) begin
      if (DEAD_CYCLES == 0) begin
        state_nxt = DRIVE;
      end else begin
        state_nxt = BLANK;
        cnt_nxt   = CNT_LOAD;
      end
    end else if (state_q == BLANK) begin
      if (cnt_q == '0) begin
        state_nxt = DRIVE;
      end else begin
        cnt_nxt = cnt_q - CW'(1);
      end
    end
  end

  // Runs of zero nibbles from the MSD downward
  always_comb begin
    lz = '0;
    lz[N_DIGITS-1] = (snap_nxt[BW-1 -: 4] == 4'h0);
    for (int i = int'(N_DIGITS) - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (snap_nxt[4*i +: 4] == 4'h0);
    end
  end

  // Output values loaded into the pin registers; driven only when the next state is DRIVE
  always_comb begin
    an_nxt   = '1;
    seg_nxt  = 7'h7F;
    dp_nxt   = 1'b1;
    err_nxt  = !valid;
    nib      = 4'h0;
    lz_blank = 1'b0;
    dp_req   = |(bus.dp_in & bus.ring);
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bus.ring[i]) begin
        nib      = snap_nxt[4*i +: 4];
        lz_blank = (i != 0) && lz[i] && bus.blank_lz;
      end
    end
    if (state_nxt == DRIVE) begin
      an_nxt  = ~bus.ring;
      seg_nxt = lz_blank ? 7'h7F : decode(nib);
      dp_nxt  = !dp_req;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp_n     = dp_q;
  assign bus.ring_err = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic against a frame-level model.
module tb_seg7_scan_driver;

  localparam int unsigned ND   = 4;
  localparam int          DEAD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seg7_scan_driver_if #(.N_DIGITS(ND)) bus ();

  seg7_scan_driver #(.N_DIGITS(ND), .DEAD_CYCLES(DEAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model: previous ring, frame snapshot, remaining dead cycles, whether a digit is lit
  logic [3:0]  m_prev;
  logic [15:0] m_snap;
  int          m_dead;
  bit          m_show;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_err;

  task automatic model_step();
    bit   ok, chg;
    int   idx;
    logic [15:0] upper;
    if (rst) begin
      m_prev = '0; m_snap = '0; m_dead = 0; m_show = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_err = 1'b0;
      return;
    end
    ok  = ($countones(bus.ring) == 1);
    chg = (bus.ring != m_prev);
    if (chg && bus.ring[0]) m_snap = bus.bcd;
    if (!ok) m_show = 0;
    else if (chg) begin m_dead = DEAD; m_show = (m_dead == 0); end
    else if (m_dead > 0) begin m_dead--; m_show = (m_dead == 0); end
    m_prev  = bus.ring;
    exp_err = !ok;
    if (m_show) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (bus.ring[i]) idx = i;
      upper   = m_snap >> (4 * idx);
      exp_an  = ~bus.ring;
      exp_seg = (bus.blank_lz && idx > 0 && upper == 16'h0) ? 7'h7F : seg_tab[4'(upper)];
      exp_dp  = !bus.dp_in[idx];
    end else begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic visit(input logic [3:0] r);
    bus.ring = r;
    repeat (DEAD + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.ring = 4'b0001; bus.bcd = 16'h1234; bus.dp_in = '0; bus.blank_lz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp_n !== 1'b1 || bus.ring_err !== 1'b0) begin
        bad++;
        $display("FAIL reset: an=%b seg=%h dp_n=%b err=%b want 1111/7f/1/0",
                 bus.an, bus.seg, bus.dp_n, bus.ring_err);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < DEAD; k++) begin
      tick();
      total++;
      if (bus.an !== 4'hF) begin
        bad++; $display("FAIL reset_dead[%0d]: an=%b want 1111", k, bus.an);
      end
    end
    tick();
    total++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'h19) begin
      bad++; $display("FAIL reset_first_digit: an=%b seg=%h want 1110/19", bus.an, bus.seg);
    end
  endtask

  task automatic test_dead_time();
    bus.ring = 4'b0010;
    for (int k = 0; k < DEAD; k++) begin
      tick();
      total++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
        bad++; $display("FAIL dead_time[%0d]: an=%b seg=%h want 1111/7f", k, bus.an, bus.seg);
      end
    end
    tick();
    total++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'h30) begin
      bad++; $display("FAIL dead_time_drive: an=%b seg=%h want 1101/30", bus.an, bus.seg);
    end
  endtask

  task automatic test_snapshot();
    visit(4'b0100);
    bus.bcd = 16'h9999;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.seg !== 7'h24) begin
        bad++; $display("FAIL snapshot_hold[%0d]: seg=%h want 24", k, bus.seg);
      end
    end
    visit(4'b1000);
    total++;
    if (bus.seg !== 7'h79) begin
      bad++; $display("FAIL snapshot_old_frame: seg=%h want 79", bus.seg);
    end
    visit(4'b0001);
    total++;
    if (bus.seg !== 7'h10) begin
      bad++; $display("FAIL snapshot_new_d0: seg=%h want 10", bus.seg);
    end
    visit(4'b0010);
    total++;
    if (bus.seg !== 7'h10) begin
      bad++; $display("FAIL snapshot_new_d1: seg=%h want 10", bus.seg);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] rs [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [6:0] want_a [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [6:0] want_b [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    bus.blank_lz = 1'b1;
    bus.bcd = 16'h0050;
    for (int d = 0; d < 4; d++) begin
      visit(rs[d]);
      total++;
      if (bus.an !== ~rs[d] || bus.seg !== want_a[d]) begin
        bad++; $display("FAIL lz_0050_d%0d: an=%b seg=%h want %b/%h", d, bus.an, bus.seg, ~rs[d], want_a[d]);
      end
    end
    bus.bcd = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      visit(rs[d]);
      total++;
      if (bus.an !== ~rs[d] || bus.seg !== want_b[d]) begin
        bad++; $display("FAIL lz_0000_d%0d: an=%b seg=%h want %b/%h", d, bus.an, bus.seg, ~rs[d], want_b[d]);
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_ring_err();
    bus.ring = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (bus.ring_err !== 1'b1 || bus.an !== 4'hF) begin
        bad++; $display("FAIL ring_err_set[%0d]: err=%b an=%b want 1/1111", k, bus.ring_err, bus.an);
      end
    end
    bus.ring = 4'b0001;
    for (int k = 0; k < DEAD; k++) begin
      tick();
      total++;
      if (bus.ring_err !== 1'b0 || bus.an !== 4'hF) begin
        bad++; $display("FAIL ring_err_recover[%0d]: err=%b an=%b want 0/1111", k, bus.ring_err, bus.an);
      end
    end
    tick();
    total++;
    if (bus.an !== 4'b1110) begin
      bad++; $display("FAIL ring_err_redrive: an=%b want 1110", bus.an);
    end
    bus.ring = 4'b0000;
    tick();
    total++;
    if (bus.ring_err !== 1'b1 || bus.an !== 4'hF) begin
      bad++; $display("FAIL ring_err_zero: err=%b an=%b want 1/1111", bus.ring_err, bus.an);
    end
  endtask

  task automatic test_decode_dp();
    bus.bcd = 16'h00B0; bus.dp_in = 4'b0010;
    visit(4'b0001);
    total++;
    if (bus.dp_n !== 1'b1 || bus.seg !== 7'h40) begin
      bad++; $display("FAIL dp_other_digit: dp_n=%b seg=%h want 1/40", bus.dp_n, bus.seg);
    end
    visit(4'b0010);
    total++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'h3F || bus.dp_n !== 1'b0) begin
      bad++; $display("FAIL dp_hex_digit: an=%b seg=%h dp_n=%b want 1101/3f/0", bus.an, bus.seg, bus.dp_n);
    end
    bus.dp_in = 4'b0000;
    tick();
    total++;
    if (bus.dp_n !== 1'b1) begin
      bad++; $display("FAIL dp_live: dp_n=%b want 1", bus.dp_n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp_n !== 1'b1 || bus.ring_err !== 1'b0) begin
      bad++; $display("FAIL reset_in_drive: an=%b seg=%h dp_n=%b err=%b want 1111/7f/1/0",
                      bus.an, bus.seg, bus.dp_n, bus.ring_err);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0)
        bus.ring = ($urandom_range(7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3));
      if ($urandom_range(15) == 0) bus.bcd = 16'($urandom);
      if ($urandom_range(7) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(31) == 0) bus.blank_lz = 1'($urandom);
      rst = ($urandom_range(399) == 0);
      tick();
      total++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp_n !== exp_dp || bus.ring_err !== exp_err) begin
        bad++;
        $display("FAIL random[%0d]: an=%b seg=%h dp_n=%b err=%b want %b/%h/%b/%b", n,
                 bus.an, bus.seg, bus.dp_n, bus.ring_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dead_time();
    test_snapshot();
    test_leading_zero();
    test_ring_err();
    test_decode_dp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
